// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the memory arbiter; grants only in IDLE.
// Fixed D-over-I priority by default, round-robin when MEM_ARB_FAIR_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  state_t state_i,
  input  logic   i_req_i,
  input  logic   d_req_i,
`ifdef MEM_ARB_FAIR_EN
  input  owner_t last_owner_i,
`endif
  output logic   grant_i_o,
  output logic   grant_d_o
);

  always_comb begin
    grant_i_o = 1'b0;
    grant_d_o = 1'b0;
    if (state_i == IDLE) begin
`ifdef MEM_ARB_FAIR_EN
      // Contention goes to whichever side did not own the port last.
      if (i_req_i && d_req_i) begin
        if (last_owner_i == OWN_D) grant_i_o = 1'b1;
        else                       grant_d_o = 1'b1;
      end else begin
        grant_i_o = i_req_i;
        grant_d_o = d_req_i;
      end
`else
      grant_d_o = d_req_i;
      grant_i_o = i_req_i && !d_req_i;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the off-chip memory port between the I-cache and D-cache miss engines.
// One transaction is held in registers until mem_ready; optional MEM_ARB_FAIR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output state_t            dbg_state_o
);

  state_t              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                grant_i, grant_d;
`ifdef MEM_ARB_FAIR_EN
  owner_t              last_owner_q, last_owner_d;
`endif

  mem_arb_pick u_pick (
    .state_i      (state_q),
    .i_req_i      (i_read),
    .d_req_i      (d_read | d_write),
`ifdef MEM_ARB_FAIR_EN
    .last_owner_i (last_owner_q),
`endif
    .grant_i_o    (grant_i),
    .grant_d_o    (grant_d)
  );

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    i_ready     = 1'b0;
    d_ready     = 1'b0;
`ifdef MEM_ARB_FAIR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          // A simultaneous read+write request is taken as a write.
          state_d     = BUSY_D;
          addr_d      = d_addr;
          wdata_d     = d_wdata;
          mem_write_d = d_write;
          mem_read_d  = !d_write;
`ifdef MEM_ARB_FAIR_EN
          last_owner_d = OWN_D;
`endif
        end else if (grant_i) begin
          state_d     = BUSY_I;
          addr_d      = i_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
`ifdef MEM_ARB_FAIR_EN
          last_owner_d = OWN_I;
`endif
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          i_ready     = 1'b1;
          state_d     = RELEASE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          d_ready     = 1'b1;
          state_d     = RELEASE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef MEM_ARB_FAIR_EN
      last_owner_q <= OWN_D;
`endif
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef MEM_ARB_FAIR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level arbitration model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int LW = 128;
  localparam int EW = 2 + AW + LW;

  logic          clk;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;
  state_t        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ready    (i_ready),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic          i_rd;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [LW-1:0] dw;
    int            lat;
    logic [LW-1:0] rd;
    bit            exp_d;
    bit            exp_wr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wd;
  } vec_t;

  vec_t vec[6];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_read    = 1'b0;
    i_addr    = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  // Ends at posedge+1 of an IDLE cycle with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    at_neg();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_state", dbg_state, IDLE);
    step();
    rst_n = 1'b1;
  endtask

  // Called at posedge+1 of the first cycle the command must be visible;
  // returns at the negedge of the following RELEASE cycle.
  task automatic serve(input bit is_d, input bit wr, input logic [AW-1:0] addr,
                       input logic [LW-1:0] wd, input int lat, input logic [LW-1:0] rd,
                       input bit noise);
    for (int k = 0; k < lat; k++) begin
      if (noise) begin
        i_addr  = AW'($urandom);
        d_addr  = AW'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      at_neg();
      chk("busy_mem_read", mem_read, !wr);
      chk("busy_mem_write", mem_write, wr);
      chk("busy_mem_addr", mem_addr, addr);
      if (wr) chk("busy_mem_wdata", mem_wdata, wd);
      chk("busy_i_ready", i_ready, 0);
      chk("busy_d_ready", d_ready, 0);
      step();
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    at_neg();
    chk("done_i_ready", i_ready, !is_d);
    chk("done_d_ready", d_ready, is_d);
    if (!wr) chk("done_rdata", is_d ? d_rdata : i_rdata, rd);
    step();
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    at_neg();
    chk("rel_mem_read", mem_read, 0);
    chk("rel_mem_write", mem_write, 0);
    chk("rel_i_ready", i_ready, 0);
    chk("rel_d_ready", d_ready, 0);
    chk("rel_state", dbg_state, RELEASE);
  endtask

  bit            last_d;
  bit            ip, dp, dwr, win_d;
  logic [AW-1:0] ia, da;
  logic [LW-1:0] dd;
  logic [EW-1:0] e;

  initial begin
    vec[0] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'hABCDEF0, 128'h0, 1, 128'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 28'hABCDEF0, 128'h0};
    vec[1] = '{1'b0, 1'b0, 1'b1, 28'h0, 28'h0000010, 128'h1234, 2, 128'h0, 1'b1, 1'b1, 28'h0000010, 128'h1234};
    vec[2] = '{1'b0, 1'b1, 1'b1, 28'h0, 28'h0000055, 128'hDEAD, 1, 128'h0, 1'b1, 1'b1, 28'h0000055, 128'hDEAD};
    vec[3] = '{1'b0, 1'b0, 1'b1, 28'h0, 28'h0000000, {LW{1'b1}}, 3, 128'h0, 1'b1, 1'b1, 28'h0000000, {LW{1'b1}}};
    vec[4] = '{1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 28'h0, 128'h0, 2, 128'hCAFE, 1'b0, 1'b0, 28'hFFFFFFF, 128'h0};
    vec[5] = '{1'b1, 1'b0, 1'b0, 28'h0000123, 28'h0, 128'h0, 4, {16{8'hA5}}, 1'b0, 1'b0, 28'h0000123, 128'h0};

    do_reset();

    // Vector table: single requester per entry, each starting from IDLE.
    for (int n = 0; n < 6; n++) begin
      i_read  = vec[n].i_rd;
      d_read  = vec[n].d_rd;
      d_write = vec[n].d_wr;
      i_addr  = vec[n].ia;
      d_addr  = vec[n].da;
      d_wdata = vec[n].dw;
      step();
      serve(vec[n].exp_d, vec[n].exp_wr, vec[n].exp_addr, vec[n].exp_wd, vec[n].lat, vec[n].rd, 1'b0);
      step();
    end

    // Simultaneous I read and D write; last owner was I, so D wins in both policies.
    i_read  = 1'b1;
    i_addr  = 28'h0000200;
    d_write = 1'b1;
    d_addr  = 28'h0000010;
    d_wdata = 128'h1234;
    step();
    serve(1'b1, 1'b1, 28'h0000010, 128'h1234, 3, 128'h0, 1'b0);
    step();
    at_neg();
    chk("gap_mem_read", mem_read, 0);
    chk("gap_state", dbg_state, IDLE);
    step();
    serve(1'b0, 1'b0, 28'h0000200, 128'h0, 2, 128'h5555_AAAA, 1'b0);
    step();

    // No preemption: D request and input noise while I owns the port.
    i_read = 1'b1;
    i_addr = 28'h0000077;
    step();
    d_read = 1'b1;
    serve(1'b0, 1'b0, 28'h0000077, 128'h0, 3, 128'h7777, 1'b1);
    d_addr = 28'h0000088;
    step();
    step();
    serve(1'b1, 1'b0, 28'h0000088, 128'h0, 1, 128'h8888, 1'b0);
    step();

    // Reset while BUSY_D, then a stray mem_ready.
    d_write = 1'b1;
    d_addr  = 28'h0000033;
    d_wdata = 128'h99;
    step();
    at_neg();
    chk("pre_rst_mem_write", mem_write, 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_inputs();
    at_neg();
    chk("mid_rst_mem_write", mem_write, 0);
    chk("mid_rst_state", dbg_state, IDLE);
    step();
    mem_ready = 1'b1;
    at_neg();
    chk("stray_i_ready", i_ready, 0);
    chk("stray_d_ready", d_ready, 0);
    chk("stray_state", dbg_state, IDLE);
    step();
    mem_ready = 1'b0;

    // Both sides held for 4 grants, after one I transaction sets last owner to I.
    do_reset();
    i_read = 1'b1;
    i_addr = 28'h0000001;
    step();
    serve(1'b0, 1'b0, 28'h0000001, 128'h0, 1, 128'h1, 1'b0);
    step();
    for (int t = 0; t < 4; t++) begin
      bit exp_d;
`ifdef MEM_ARB_FAIR_EN
      exp_d = (t % 2) == 0;
`else
      exp_d = 1'b1;
`endif
      i_read = 1'b1;
      i_addr = AW'(32'h100 + t);
      d_read = 1'b1;
      d_addr = AW'(32'h200 + t);
      step();
      serve(exp_d, 1'b0, exp_d ? AW'(32'h200 + t) : AW'(32'h100 + t), 128'h0, 1,
            LW'(32'hF00 + t), 1'b0);
      step();
    end
    d_read = 1'b0;
    i_read = 1'b1;
    i_addr = 28'h0000300;
    step();
    serve(1'b0, 1'b0, 28'h0000300, 128'h0, 1, 128'h300, 1'b0);

    // Randomized traffic against a transaction-level arbitration model.
    do_reset();
    last_d = 1'b1;
    ip = 1'b0;
    dp = 1'b0;
    dwr = 1'b0;
    ia = '0;
    da = '0;
    dd = '0;
    for (int r = 0; r < 40; r++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1'b1;
        ia = AW'($urandom);
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp  = 1'b1;
        da  = AW'($urandom);
        dd  = {$urandom, $urandom, $urandom, $urandom};
        dwr = 1'($urandom_range(0, 1));
      end
      if (!ip && !dp) begin
        ip = 1'b1;
        ia = AW'($urandom);
      end
      i_read  = ip;
      i_addr  = ia;
      d_write = dp && dwr;
      d_read  = dp && (!dwr || $urandom_range(0, 3) == 0);
      d_addr  = da;
      d_wdata = dd;
`ifdef MEM_ARB_FAIR_EN
      win_d = dp && (!ip || !last_d);
`else
      win_d = dp;
`endif
      last_d = win_d;
      exp_q.push_back({win_d, win_d && dwr, win_d ? da : ia, win_d ? dd : {LW{1'b0}}});
      if (r > 0) step();
      step();
      if (!win_d && !dp && $urandom_range(0, 2) == 0) begin
        dp  = 1'b1;
        da  = AW'($urandom);
        dd  = {$urandom, $urandom, $urandom, $urandom};
        dwr = 1'($urandom_range(0, 1));
        d_write = dwr;
        d_read  = !dwr;
        d_addr  = da;
        d_wdata = dd;
      end
      if (win_d && !ip && $urandom_range(0, 2) == 0) begin
        ip = 1'b1;
        ia = AW'($urandom);
        i_read = 1'b1;
        i_addr = ia;
      end
      e = exp_q.pop_front();
      serve(e[EW-1], e[EW-2], e[LW+AW-1:LW], e[LW-1:0], $urandom_range(1, 4),
            {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      if (win_d) dp = 1'b0;
      else       ip = 1'b0;
    end
    chk("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
